// File: rtl/intersection_pkg.sv
// Shared types and default timing for the two-road intersection sequencer.
package intersection_pkg;

    localparam int unsigned CNT_W_DEF    = 8;
    localparam int unsigned GREEN_DEF    = 8;
    localparam int unsigned YELLOW_DEF   = 3;
    localparam int unsigned ALL_RED_DEF  = 2;
    localparam int unsigned PED_WALK_DEF = 6;

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        CLR  = 3'd2,
        WALK = 3'd3,
        EW_G = 3'd4,
        EW_Y = 3'd5
    } phase_t;

endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// Phase timer: restarts at 0 on load, flags the last cycle of a phase.
module phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             load,
    input  logic             saturate,
    input  logic [CNT_W-1:0] duration,
    output logic             done
);

    logic [CNT_W-1:0] count;

    assign done = (count == duration - CNT_W'(1));

    // Saturating hold keeps done asserted while the resting phase waits for demand.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (!(saturate && done)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road intersection sequencer with pedestrian phase; NS rests on green.
module intersection_ctrl
    import intersection_pkg::*;
#(
    parameter int unsigned GREEN    = GREEN_DEF,
    parameter int unsigned YELLOW   = YELLOW_DEF,
    parameter int unsigned ALL_RED  = ALL_RED_DEF,
    parameter int unsigned PED_WALK = PED_WALK_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_ew_car,
    input  logic i_ped_req,
    output logic o_ns_green,
    output logic o_ns_yellow,
    output logic o_ns_red,
    output logic o_ew_green,
    output logic o_ew_yellow,
    output logic o_ew_red,
    output logic o_walk,
    output logic o_ped_wait
);

    phase_t           state;
    phase_t           state_next;
    phase_t           nxt;
    phase_t           nxt_next;
    logic             ew_pend;
    logic             ped_pend;
    logic [CNT_W-1:0] duration;
    logic             done;
    logic             leave;
    logic             hold_green;

    assign hold_green = (state == NS_G);
    assign o_ped_wait = ped_pend;

    always_comb begin
        case (state)
            NS_G, EW_G: duration = CNT_W'(GREEN);
            NS_Y, EW_Y: duration = CNT_W'(YELLOW);
            WALK:       duration = CNT_W'(PED_WALK);
            default:    duration = CNT_W'(ALL_RED);
        endcase
    end

    phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .i_rst_n  (i_rst_n),
        .load     (leave),
        .saturate (hold_green),
        .duration (duration),
        .done     (done)
    );

    always_comb begin
        state_next = state;
        nxt_next   = nxt;
        case (state)
            NS_G: if (done && (ew_pend || ped_pend)) state_next = NS_Y;
            NS_Y: if (done) begin
                state_next = CLR;
                nxt_next   = ped_pend ? WALK : EW_G;
            end
            CLR:  if (done) state_next = nxt;
            WALK: if (done) begin
                state_next = CLR;
                nxt_next   = ew_pend ? EW_G : NS_G;
            end
            EW_G: if (done) state_next = EW_Y;
            EW_Y: if (done) begin
                state_next = CLR;
                nxt_next   = NS_G;
            end
            default: begin
                state_next = CLR;
                nxt_next   = NS_G;
            end
        endcase
        leave = (state_next != state);
    end

    // Lamps decode the upcoming state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= CLR;
            nxt         <= NS_G;
            ew_pend     <= 1'b0;
            ped_pend    <= 1'b0;
            o_ns_green  <= 1'b0;
            o_ns_yellow <= 1'b0;
            o_ns_red    <= 1'b1;
            o_ew_green  <= 1'b0;
            o_ew_yellow <= 1'b0;
            o_ew_red    <= 1'b1;
            o_walk      <= 1'b0;
        end else begin
            state       <= state_next;
            nxt         <= nxt_next;
            ped_pend    <= (ped_pend | i_ped_req) & (state != WALK) & (state_next != WALK);
            ew_pend     <= (ew_pend | i_ew_car) & (state != EW_G) & (state_next != EW_G);
            o_ns_green  <= (state_next == NS_G);
            o_ns_yellow <= (state_next == NS_Y);
            o_ns_red    <= (state_next != NS_G) && (state_next != NS_Y);
            o_ew_green  <= (state_next == EW_G);
            o_ew_yellow <= (state_next == EW_Y);
            o_ew_red    <= (state_next != EW_G) && (state_next != EW_Y);
            o_walk      <= (state_next == WALK);
        end
    end

endmodule

// File: doc/intersection_ctrl.md
Name: intersection_ctrl

Overview:
Two-road intersection sequencer: a main road (NS) and a side road (EW), plus a pedestrian crossing.
- NS rests on green. The block leaves NS green only after a minimum green time, and only if an EW vehicle or a pedestrian request is pending.
- Every direction change passes through an all-red clearance.
- Each road's light outputs are one-hot green/yellow/red, matching the single-light block the team already verifies.

Parameters:
GREEN, 8, green duration in cycles (minimum for NS, exact for EW)
YELLOW, 3, yellow duration in cycles (both roads)
ALL_RED, 2, all-red clearance duration in cycles
PED_WALK, 6, walk-phase duration in cycles
CNT_W, 8, phase timer width; every duration must be in 1..2^CNT_W-1, and 0 is illegal

Ports:
clk  input  1  system clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_ew_car  input  1  side-road vehicle detect; level or single-cycle pulse
i_ped_req  input  1  pedestrian button; level or single-cycle pulse
o_ns_green  output  1  NS green
o_ns_yellow  output  1  NS yellow
o_ns_red  output  1  NS red
o_ew_green  output  1  EW green
o_ew_yellow  output  1  EW yellow
o_ew_red  output  1  EW red
o_walk  output  1  pedestrian walk signal
o_ped_wait  output  1  pedestrian request latched, not yet served

Behaviour:
- States: NS_G, NS_Y, CLR, WALK, EW_G, EW_Y. A registered nxt field holds the state that follows CLR.
- All outputs are registered and update on the same edge as the state.
- Per road, exactly one of green/yellow/red is high at all times. NS red is high in every state except NS_G and NS_Y; EW red is high in every state except EW_G and EW_Y.
- o_walk is high only in WALK. No vehicle green or yellow may be high while o_walk is high.
- Reset (asynchronous, effective immediately, including mid-phase):
  - state=CLR, nxt=NS_G, timer=0, both pending flags=0.
  - o_ns_red=1, o_ew_red=1, all other outputs 0.
- Phase timer loads 0 on every state entry and increments each cycle. A phase of duration N keeps its outputs high for exactly N cycles.
- NS_G: the timer saturates at GREEN-1. At timer==GREEN-1, if ew_pend or ped_pend is set, go to NS_Y on the next edge; otherwise hold NS_G indefinitely.
- NS_Y: after YELLOW cycles go to CLR, with nxt=WALK if ped_pend else nxt=EW_G.
- CLR: after ALL_RED cycles go to nxt.
- WALK: after PED_WALK cycles go to CLR, with nxt=EW_G if ew_pend else nxt=NS_G.
- EW_G: exactly GREEN cycles, then EW_Y.
- EW_Y: after YELLOW cycles go to CLR with nxt=NS_G. A pedestrian request pending here is served after the next NS minimum green.
- Pending flags:
  - ped_pend <= (ped_pend | i_ped_req) & (state!=WALK)
  - ew_pend <= (ew_pend | i_ew_car) & (state!=EW_G)
  - Requests arriving while their own phase is active are discarded, including on the entry edge.
  - o_ped_wait = ped_pend, registered.
- Simultaneous EW and pedestrian pending at NS_Y exit: walk is served first, then EW. Sequence: NS_Y, CLR, WALK, CLR, EW_G, EW_Y, CLR, NS_G.
- Timer never wraps. The comparison is against duration-1 at CNT_W width.

Decomposition:
- Shared package intersection_pkg holds:
  - state encoding as localparams (3-bit, binary)
  - default durations
  - CNT_W
- One natural sub-module, phase_timer:
  - inputs: clk, i_rst_n, load, duration
  - output: done, high when count==duration-1
  - includes a saturate option for the NS_G hold
- The FSM, pending latches and output decode stay in intersection_ctrl.

Test Plan:
1. Reset release, no requests, defaults. Expect all-red for 2 cycles, then NS green, held for 50 or more cycles. EW red and o_walk=0 throughout.
2. Pulse i_ew_car for 1 cycle at NS_G timer=3. Expect NS green 8 cycles total, NS yellow 3, all-red 2, EW green 8, EW yellow 3, all-red 2, then NS green held.
3. Pulse i_ped_req during NS_G. Expect o_ped_wait=1 from the next edge, then NS yellow 3, all-red 2. Then o_walk for 6 cycles with both roads red and o_ped_wait cleared on WALK entry, then all-red 2, then NS green.
4. Assert i_ew_car and i_ped_req together. Expect NS_Y, CLR, WALK(6), CLR(2), EW_G(8), EW_Y(3), CLR(2), NS_G; one-hot checker passes on every cycle.
5. Pulse i_ped_req during WALK and i_ew_car during EW_G. Expect both ignored: no second walk or EW phase, NS green held afterwards.
6. Assert i_rst_n low for 1 cycle mid EW_G. Expect outputs to go all-red asynchronously, before the next clock edge, and pending flags cleared. After release: 2 all-red cycles, then NS green.
